// File: rtl/bsg_demux2_pkg.sv
// Shared types for the buffered 2-way bitwise demux: channel occupancy encoding
// and buffer depth.
package bsg_demux2_pkg;

    localparam int unsigned ENTRIES = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_e;

    // Occupancy update for one cycle; saturates at both ends.
    function automatic count_e count_next(input count_e cur, input logic enq, input logic deq);
        count_e nxt;
        nxt = cur;
        case ({enq, deq})
            2'b10: begin
                case (cur)
                    EMPTY:   nxt = ONE;
                    ONE:     nxt = FULL;
                    default: nxt = FULL;
                endcase
            end
            2'b01: begin
                case (cur)
                    FULL:    nxt = ONE;
                    ONE:     nxt = EMPTY;
                    default: nxt = EMPTY;
                endcase
            end
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bsg_demux2_two_fifo.sv
// Two-entry in-order channel buffer. Head data and valid come straight from
// registered storage, so nothing on the enqueue side reaches the outputs combinationally.
module bsg_demux2_two_fifo
    import bsg_demux2_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               enq_i,
    input  logic               ready_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               full_o
);

    localparam int unsigned ptr_w_lp = $clog2(ENTRIES);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q;
    logic [ptr_w_lp-1:0] rd_ptr_q;
    count_e              count_q;

    logic enq_ok;
    logic deq;

    // The top already withholds ready when full; the guard keeps storage safe regardless.
    assign enq_ok = enq_i & (count_q != FULL);
    assign deq    = (count_q != EMPTY) & ready_i;

    assign v_o    = (count_q != EMPTY);
    assign full_o = (count_q == FULL);
    assign data_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < els_p; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= EMPTY;
        end else begin
            if (enq_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_next(count_q, enq_ok, deq);
        end
    end

endmodule

// File: rtl/bsg_demux2_gatestack_buffered.sv
// Per-bit 2-way demux feeding two independent 2-entry channel buffers.
// Optional BSG_DEMUX2_SKIP_EMPTY_EN: a channel whose routed word is all-zero is not written.
module bsg_demux2_gatestack_buffered
    import bsg_demux2_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = ENTRIES
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic [width_p-1:0] sel_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] o0_o,
    output logic [width_p-1:0] o1_o,
    output logic               v0_o,
    output logic               v1_o,
    input  logic               ready0_i,
    input  logic               ready1_i
);

    logic [width_p-1:0] route0;
    logic [width_p-1:0] route1;
    logic               enq;
    logic               enq0;
    logic               enq1;
    logic               full0;
    logic               full1;
    logic               rst_done_q;

    assign route0 = data_i & ~sel_i;
    assign route1 = data_i & sel_i;

    // Ready is built only from flops so it never follows the consumer readies.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
        end
    end

    assign ready_o = rst_done_q & ~full0 & ~full1;
    assign enq     = v_i & ready_o;

`ifdef BSG_DEMUX2_SKIP_EMPTY_EN
    assign enq0 = enq & (|route0);
    assign enq1 = enq & (|route1);
`else
    assign enq0 = enq;
    assign enq1 = enq;
`endif

    bsg_demux2_two_fifo #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_fifo0 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (route0),
        .enq_i     (enq0),
        .ready_i   (ready0_i),
        .v_o       (v0_o),
        .data_o    (o0_o),
        .full_o    (full0)
    );

    bsg_demux2_two_fifo #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_fifo1 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (route1),
        .enq_i     (enq1),
        .ready_i   (ready1_i),
        .v_o       (v1_o),
        .data_o    (o1_o),
        .full_o    (full1)
    );

endmodule

// File: tb/tb_bsg_demux2_gatestack_buffered.sv
// Directed bench for the buffered 2-way demux with a per-channel scoreboard.
module tb_bsg_demux2_gatestack_buffered;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         reset_n_i;
    logic [W-1:0] data_i;
    logic [W-1:0] sel_i;
    logic         v_i;
    logic         ready_o;
    logic [W-1:0] o0_o;
    logic [W-1:0] o1_o;
    logic         v0_o;
    logic         v1_o;
    logic         ready0_i;
    logic         ready1_i;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic         model_rdy_en;

    bsg_demux2_gatestack_buffered #(.width_p(W), .els_p(2)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (data_i),
        .sel_i     (sel_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .o0_o      (o0_o),
        .o1_o      (o1_o),
        .v0_o      (v0_o),
        .v1_o      (v1_o),
        .ready0_i  (ready0_i),
        .ready1_i  (ready1_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Ready becomes legal one edge after reset release.
    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) model_rdy_en <= 1'b0;
        else            model_rdy_en <= 1'b1;
    end

    always @(negedge reset_n_i) begin
        q0.delete();
        q1.delete();
    end

    // Scoreboard: compare current contents, then apply the coming edge's deq/enq.
    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1) begin
            check("v0_vs_model", {7'd0, v0_o}, {7'd0, q0.size() > 0});
            check("v1_vs_model", {7'd0, v1_o}, {7'd0, q1.size() > 0});
            if (model_rdy_en)
                check("ready_vs_model", {7'd0, ready_o}, {7'd0, (q0.size() < 2) && (q1.size() < 2)});
            else
                check("ready_pre_edge", {7'd0, ready_o}, 8'h00);
            if (v0_o && q0.size() > 0) check("ch0_head", o0_o, q0[0]);
            if (v1_o && q1.size() > 0) check("ch1_head", o1_o, q1[0]);
            if (v0_o && ready0_i && q0.size() > 0) void'(q0.pop_front());
            if (v1_o && ready1_i && q1.size() > 0) void'(q1.pop_front());
            if (v_i && ready_o) begin
`ifdef BSG_DEMUX2_SKIP_EMPTY_EN
                if ((data_i & ~sel_i) != '0) q0.push_back(data_i & ~sel_i);
                if ((data_i & sel_i) != '0)  q1.push_back(data_i & sel_i);
`else
                q0.push_back(data_i & ~sel_i);
                q1.push_back(data_i & sel_i);
`endif
            end
        end
    end

    initial begin
        reset_n_i = 1'b0;
        data_i    = '0;
        sel_i     = '0;
        v_i       = 1'b0;
        ready0_i  = 1'b1;
        ready1_i  = 1'b1;

        // Reset and idle
        tick();
        tick();
        check("rst_ready", {7'd0, ready_o}, 8'h00);
        check("rst_v0", {7'd0, v0_o}, 8'h00);
        check("rst_v1", {7'd0, v1_o}, 8'h00);
        check("rst_o0", o0_o, 8'h00);
        check("rst_o1", o1_o, 8'h00);
        reset_n_i = 1'b1;
        #1;
        check("ready_at_release", {7'd0, ready_o}, 8'h00);
        @(posedge clk_i);
        #1;
        check("ready_after_release", {7'd0, ready_o}, 8'h01);

        // Split routing, one-cycle latency, one cycle of valid each
        data_i = 8'hA5; sel_i = 8'hF0; v_i = 1'b1;
        tick();
        v_i = 1'b0;
        check("split_o0", o0_o, 8'h05);
        check("split_o1", o1_o, 8'hA0);
        check("split_v0", {7'd0, v0_o}, 8'h01);
        check("split_v1", {7'd0, v1_o}, 8'h01);
        tick();
        check("split_v0_gone", {7'd0, v0_o}, 8'h00);
        check("split_v1_gone", {7'd0, v1_o}, 8'h00);

        // Backpressure on channel 1
        ready1_i = 1'b0;
        data_i = 8'h11; sel_i = 8'hFF; v_i = 1'b1;
        tick();
        data_i = 8'h22;
        tick();
        check("bp_ready_low", {7'd0, ready_o}, 8'h00);
        data_i = 8'h33;
        tick();
        tick();
        check("bp_ready_held", {7'd0, ready_o}, 8'h00);
        check("bp_head_11", o1_o, 8'h11);
        ready1_i = 1'b1;
        tick();
        check("bp_head_22", o1_o, 8'h22);
        check("bp_ready_back", {7'd0, ready_o}, 8'h01);
        tick();
        v_i = 1'b0;
        check("bp_head_33", o1_o, 8'h33);
        tick();
        check("bp_drained", {7'd0, v1_o}, 8'h00);

        // Simultaneous enq/deq at count 1 on channel 0
        ready0_i = 1'b0;
        data_i = 8'h01; sel_i = 8'h00; v_i = 1'b1;
        tick();
        check("sim_head_01", o0_o, 8'h01);
        ready0_i = 1'b1;
        data_i = 8'h02;
        tick();
        v_i = 1'b0;
        check("sim_v0", {7'd0, v0_o}, 8'h01);
        check("sim_head_02", o0_o, 8'h02);
        tick();
        check("sim_empty", {7'd0, v0_o}, 8'h00);

        // All-zero routed word on channel 0
        data_i = 8'h5A; sel_i = 8'hFF; v_i = 1'b1;
        tick();
        v_i = 1'b0;
`ifdef BSG_DEMUX2_SKIP_EMPTY_EN
        check("skip_v0", {7'd0, v0_o}, 8'h00);
`else
        check("skip_v0", {7'd0, v0_o}, 8'h01);
        check("skip_o0", o0_o, 8'h00);
`endif
        check("skip_o1", o1_o, 8'h5A);
        tick();

        // Mid-operation reset with both channels full
        ready0_i = 1'b0; ready1_i = 1'b0;
        data_i = 8'h3C; sel_i = 8'h0F; v_i = 1'b1;
        tick();
        data_i = 8'hC3;
        tick();
        v_i = 1'b0;
        check("mid_full_ready", {7'd0, ready_o}, 8'h00);
        #1;
        reset_n_i = 1'b0;
        #1;
        check("mid_v0", {7'd0, v0_o}, 8'h00);
        check("mid_v1", {7'd0, v1_o}, 8'h00);
        check("mid_o0", o0_o, 8'h00);
        check("mid_o1", o1_o, 8'h00);
        check("mid_ready", {7'd0, ready_o}, 8'h00);
        reset_n_i = 1'b1;
        ready0_i = 1'b1; ready1_i = 1'b1;
        tick();
        tick();
        tick();
        check("post_v0", {7'd0, v0_o}, 8'h00);
        check("post_v1", {7'd0, v1_o}, 8'h00);
        check("post_ready", {7'd0, ready_o}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_demux2_gatestack_buffered.md
BSG_DEMUX2_GATESTACK_BUFFERED -- requirements
Module: bsg_demux2_gatestack_buffered

Interface
REQ-001 Parameter width_p, default 64, SHALL set the word width of data and per-bit select.
REQ-002 Parameter els_p, default 2, SHALL set the entries per output channel buffer; only the value 2 is supported.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n_i  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 data_i  input  width_p  SHALL be the input word.
REQ-006 sel_i  input  width_p  SHALL be the per-bit route: 0 sends the bit to channel 0, 1 sends it to channel 1.
REQ-007 v_i  input  1  SHALL be input valid.
REQ-008 ready_o  output  1  SHALL be input ready.
REQ-009 o0_o / o1_o  output  width_p each  SHALL be the head data of channel 0 / channel 1.
REQ-010 v0_o / v1_o  output  1 each  SHALL be channel valid.
REQ-011 ready0_i / ready1_i  input  1 each  SHALL be the channel consumer ready.

Function
REQ-012 The input handshake SHALL complete (enq) when v_i & ready_o are both high at a rising edge.
REQ-013 On enq, channel 0 SHALL receive data_i & ~sel_i and channel 1 SHALL receive data_i & sel_i; non-routed bits are 0.
REQ-014 Each channel SHALL be a 2-entry in-order buffer with a count of 0, 1 or 2 (EMPTY, ONE, FULL).
REQ-015 ready_o SHALL be 1 iff both channel counts are < 2.
REQ-016 ready_o SHALL depend only on registered state and SHALL NOT depend combinationally on ready0_i or ready1_i.
REQ-017 vK_o SHALL be 1 iff count_K > 0, and oK_o SHALL present the oldest entry.
REQ-018 Channel K SHALL dequeue when vK_o & readyK_i is high at a rising edge; the two channels dequeue independently.
REQ-019 Latency SHALL be one cycle: a word enqueued at edge N is visible on an empty channel's output after edge N.
REQ-020 No combinational path SHALL exist from data_i, sel_i or v_i to any output.
REQ-021 Simultaneous enq and deq at count 1 SHALL leave the count at 1, with the new word at the head after the edge.
REQ-022 Simultaneous enq and deq at count 0 is impossible because vK_o is 0, so the count SHALL go 0->1.
REQ-023 At count 2, enq SHALL be blocked because ready_o is 0; a deq SHALL go 2->1, and ready_o SHALL rise the next cycle if the other channel is also < 2.
REQ-024 Buffer pointers SHALL wrap modulo 2.
REQ-025 Order SHALL be preserved per channel.
REQ-026 When v_i is high and ready_o is low, the bench holds data_i/sel_i stable; the block SHALL require no behaviour for a violation.

Reset
REQ-027 While reset_n_i is low: all counts and pointers SHALL be 0; v0_o=v1_o=0; o0_o=o1_o=0 (storage cleared); ready_o=0.
REQ-028 ready_o SHALL become 1 in the first cycle after reset_n_i deasserts.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered words immediately, with no edge needed.

Configuration
REQ-030 The feature SHALL be controlled by macro BSG_DEMUX2_SKIP_EMPTY_EN.
REQ-031 With BSG_DEMUX2_SKIP_EMPTY_EN defined: on enq, a channel whose routed mask is all-zero SHALL NOT be written and its count SHALL be unchanged.
REQ-032 With the macro defined, ready_o SHALL still require both counts < 2.
REQ-033 Without the macro, both channels SHALL be written on every enq, including all-zero words.

Structure
REQ-034 A shared package bsg_demux2_pkg SHALL hold the count enum (EMPTY/ONE/FULL) and a localparam for the entry count of 2.
REQ-035 Sub-module bsg_demux2_two_fifo SHALL implement one 2-entry channel buffer and SHALL be instantiated twice.
REQ-036 Routing and ready logic SHALL live in the top module.

Verification
REQ-037 Bench SHALL run with width_p=8.
REQ-038 Reset/idle: hold reset_n_i=0 -> ready_o=0, v0_o=v1_o=0, o0_o=o1_o=8'h00; release -> ready_o=1 the next cycle.
REQ-039 Split routing: data_i=8'hA5, sel_i=8'hF0, v_i=1, consumers ready -> next cycle o0_o=8'h05, o1_o=8'hA0, v0_o=v1_o=1, each for exactly one cycle.
REQ-040 Backpressure: ready1_i=0, enq 8'h11 then 8'h22 with sel_i=8'hFF -> ready_o=0 after the 2nd enq; 3rd word held; ready1_i=1 -> o1_o=8'h11 then 8'h22, then the 3rd word is accepted, in order.
REQ-041 Simultaneous enq/deq at count 1: channel 0 holds 8'h01, ready0_i=1, enq 8'h02 with sel_i=0 on the same edge -> count stays 1, o0_o=8'h02.
REQ-042 Skip-empty: enq with sel_i=8'hFF -> with macro, v0_o stays 0; without macro, v0_o=1 and o0_o=8'h00.
REQ-043 Mid-operation reset: both channels FULL, pulse reset_n_i low between edges -> v0_o=v1_o=0 immediately, and nothing from before the reset is ever output.
